dmem_mmio_uart: RTL and testbench
=================================

# dmem_mmio_uart

Data-side bus splitter between the core's data-memory port and the data memory, adding a memory-mapped UART transmitter. CPU accesses inside a 16-byte MMIO window are routed to the UART registers. All other accesses pass through unchanged to the data memory. Stored bytes are queued in a FIFO and serialized 8N1 on `uart_tx`. The single-cycle core cannot stall, so a full FIFO drops bytes and flags overflow.

## Interface

- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥2.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of 2, ≥2.
- `UART_BASE`, 32'hFFFF_FF00: MMIO window base; bits [3:0] must be zero.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_we` in 1: CPU data write enable.
- `cpu_addr` in 32: CPU data byte address, word-aligned.
- `cpu_wdata` in 32: CPU store data.
- `cpu_rdata` out 32: load data returned to the CPU (combinational).
- `mem_we` out 1: data-memory write enable.
- `mem_addr` out 32: data-memory address (= `cpu_addr`).
- `mem_wdata` out 32: data-memory write data (= `cpu_wdata`).
- `mem_rdata` in 32: data-memory read data (combinational).
- `uart_tx` out 1: serial output; idles high.
- `tx_busy` out 1: high while the FIFO is non-empty or a frame is in progress.

## Operation

- **Decode:**
  - `hit = (cpu_addr[31:4] == UART_BASE[31:4])`.
  - `mem_we = cpu_we & ~hit`.
  - `cpu_rdata = hit ? reg_rdata : mem_rdata`.
- **Registers, selected by `cpu_addr[3:2]`:**
  - 0 TXDATA. A write pushes `cpu_wdata[7:0]`. Reads return 0.
  - 1 STATUS. Reads return {29'b0, overflow, full, tx_busy}. Any write clears `overflow`.
  - 2 COUNT. Reads return FIFO occupancy, zero-extended; range 0..FIFO_DEPTH. Writes are ignored.
  - 3 reserved. Reads return 0; writes are ignored.
- **FIFO:**
  - Circular buffer with read/write pointers and a count.
  - `full = (count == FIFO_DEPTH)`.
  - A push while `full` is dropped and sets sticky `overflow`, even if a pop occurs in the same cycle.
  - Simultaneous push (not full) and pop leaves `count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Serializer FSM:**
  - IDLE: `uart_tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive 8 bits LSB first, CLKS_PER_BIT cycles each, using a bit index 0..7. After bit 7, go to STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - The baud counter counts 0..CLKS_PER_BIT-1 and resets on every state change.
- `uart_tx` is registered: it is driven from state and the shift register, never from the FIFO output directly.

## Timing

- **Reset values:**
  - `uart_tx`=1, `tx_busy`=0, FIFO empty (COUNT=0), `overflow`=0, FSM IDLE, counters 0.
  - `cpu_rdata`, `mem_*` are combinational with no reset value.
- **Reset mid-frame:** in the cycle after `reset` is sampled high, `uart_tx` is 1 and all queued bytes are discarded.
- **Latency:**
  - A TXDATA write in cycle N makes the FIFO non-empty in N+1.
  - The FSM pops at the end of N+1.
  - `uart_tx` falls at the start of N+2.
- **Frame length:** 10·CLKS_PER_BIT cycles.
- **Back-to-back frames:** the falling edge of a stop bit's successor start bit occurs exactly 10·CLKS_PER_BIT cycles after the previous start edge.
- **Register read visibility:** MMIO reads are combinational from current register state. A write in cycle N is visible to a read in N+1.
- **Data-memory pass-through:** zero added latency; `mem_we` asserts in the same cycle as `cpu_we`.

## Test plan

Test parameters: CLKS_PER_BIT=4, FIFO_DEPTH=8.

- **Single byte:** write 0x55 to 0xFFFF_FF00 at cycle 0 → `uart_tx` low during cycles 2–5, then data bits 1,0,1,0,1,0,1,0 (4 cycles each), then stop high during cycles 38–41. `tx_busy` falls at cycle 42.
- **Pass-through:** write 0x0000_1234 to 0x40 → `mem_we`=1, `mem_addr`=0x40, `mem_wdata`=0x1234, `uart_tx` stays 1. A load from 0x40 with `mem_rdata`=0xDEAD_BEEF → `cpu_rdata`=0xDEAD_BEEF. An MMIO write → `mem_we`=0.
- **Overflow:** 10 consecutive TXDATA writes of 0x00..0x09 in cycles 0–9 → bytes 0x00..0x08 are transmitted in order and 0x09 is dropped. COUNT reads 8 at cycle 10. STATUS reads 0x7; after a write to STATUS, it reads 0x3.
- **Back-to-back:** write 0xA1 and 0xB2 in consecutive cycles → two contiguous frames with start edges at cycles 2 and 42, and no idle-high gap beyond the stop bit.
- **Reset mid-frame:** queue 3 bytes, assert `reset` at cycle 15 (in DATA) → from cycle 16: `uart_tx`=1, COUNT=0, STATUS=0. No further frames are sent.
- **Reserved register:** read 0xFFFF_FF0C → 0. A write to it leaves the FIFO and `mem_we` unaffected.

Source files
------------

// File: rtl/dmem_mmio_uart.sv
// Data-side bus splitter: routes a 16-byte MMIO window to a UART transmitter
// (TX FIFO plus 8N1 serializer) and passes every other access straight
// through to the data memory.
module dmem_mmio_uart #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] UART_BASE    = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Address decode and FIFO bookkeeping signals
    logic          hit;
    logic [1:0]    sel;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          status_wr;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   reg_rdata;

    // Serializer state
    state_t        state;
    state_t        state_next;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          baud_done;
    logic          tx_next;

    assign hit       = (cpu_addr[31:4] == UART_BASE[31:4]);
    assign sel       = cpu_addr[3:2];
    assign mem_we    = cpu_we & ~hit;
    assign mem_addr  = cpu_addr;
    assign mem_wdata = cpu_wdata;
    assign cpu_rdata = hit ? reg_rdata : mem_rdata;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push_req  = cpu_we & hit & (sel == 2'd0);
    assign push      = push_req & ~full;
    assign status_wr = cpu_we & hit & (sel == 2'd1);
    assign tx_busy   = ~empty | (state != S_IDLE);
    assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    // MMIO register read mux; reflects current register state only
    always_comb begin
        reg_rdata = 32'd0;
        case (sel)
            2'd1:    reg_rdata = {29'd0, overflow, full, tx_busy};
            2'd2:    reg_rdata = 32'(count);
            default: reg_rdata = 32'd0;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cpu_wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (status_wr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Serializer next-state logic; the line level is derived from the
    // next state so uart_tx can be registered without a cycle of lag
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + 1'b1;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                baud_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    state_next = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr];
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                baud_next  = '0;
                state_next = S_IDLE;
            end
        endcase
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // Serializer state register and registered serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            uart_tx  <= tx_next;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_uart.sv
// Testbench for dmem_mmio_uart: directed scenarios plus random bus traffic,
// every cycle compared against a frame-level reference model.
module tb_dmem_mmio_uart;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;
    localparam int          FRAME = 10 * CPB;

    logic        clk;
    logic        reset;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        tx_busy;

    int total_checks;
    int bad_checks;

    // Reference model: bytes waiting, the frame on the wire and its position
    logic [7:0] model_q[$];
    bit         model_active;
    int         model_pos;
    logic [7:0] model_cur;
    bit         model_ovf;

    dmem_mmio_uart #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .UART_BASE   (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int bit_no;
        if (!model_active) return 1'b1;
        bit_no = model_pos / CPB;
        if (bit_no == 0) return 1'b0;
        if (bit_no <= 8) return model_cur[bit_no-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_reg(input logic [1:0] sel);
        logic busy;
        logic full;
        busy = model_active || (model_q.size() > 0);
        full = (model_q.size() == DEPTH);
        case (sel)
            2'd1:    return {29'd0, model_ovf, full, busy};
            2'd2:    return 32'(model_q.size());
            default: return 32'd0;
        endcase
    endfunction

    // Advances the model by one clock edge given this cycle's inputs
    task automatic modelStep(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic rst);
        int  pre;
        bit  take;
        bit  in_win;
        if (rst) begin
            model_q.delete();
            model_active = 0;
            model_pos    = 0;
            model_ovf    = 0;
            return;
        end
        pre    = model_q.size();
        in_win = (addr[31:4] == BASE[31:4]);
        take   = 0;
        if (model_active) begin
            model_pos++;
            if (model_pos == FRAME) begin
                model_active = 0;
                take = (pre > 0);
            end
        end else begin
            take = (pre > 0);
        end
        if (take) begin
            model_cur    = model_q.pop_front();
            model_active = 1;
            model_pos    = 0;
        end
        if (we && in_win && addr[3:2] == 2'd0) begin
            if (pre == DEPTH) model_ovf = 1;
            else model_q.push_back(wdata[7:0]);
        end else if (we && in_win && addr[3:2] == 2'd1) begin
            model_ovf = 0;
        end
    endtask

    // Drives one cycle of inputs, checks all outputs, then advances the model
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] mrd, input logic rst);
        logic in_win;
        @(negedge clk);
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        mem_rdata = mrd;
        reset     = rst;
        #1;
        in_win = (addr[31:4] == BASE[31:4]);
        checkOutput("uart_tx", 32'(uart_tx), 32'(model_tx()));
        checkOutput("tx_busy", 32'(tx_busy), 32'(model_active || model_q.size() > 0));
        checkOutput("mem_we", 32'(mem_we), 32'(we & ~in_win));
        checkOutput("mem_addr", mem_addr, addr);
        checkOutput("mem_wdata", mem_wdata, wdata);
        checkOutput("cpu_rdata", cpu_rdata, in_win ? model_reg(addr[3:2]) : mrd);
        modelStep(we, addr, wdata, rst);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0000_0100, 32'd0, $urandom, 1'b0);
    endtask

    // Directed scenarios followed by random traffic
    initial begin
        logic [31:0] addr;
        logic        we;
        total_checks = 0;
        bad_checks   = 0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        mem_rdata = 32'd0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        modelStep(1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, BASE + 32'h4, 32'd0, 32'd0, 1'b0);
        checkOutput("reset_status", cpu_rdata, 32'd0);

        $display("[TB] single byte");
        applyStimulus(1'b1, BASE, 32'h0000_0055, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'h40, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'h40, 32'd0, 32'd0, 1'b0);
        checkOutput("start_bit_cycle2", 32'(uart_tx), 32'd0);
        idleCycles(45);

        $display("[TB] pass-through");
        applyStimulus(1'b1, 32'h40, 32'h0000_1234, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'h40, 32'd0, 32'hDEAD_BEEF, 1'b0);
        checkOutput("load_passthru", cpu_rdata, 32'hDEAD_BEEF);
        applyStimulus(1'b1, BASE + 32'h8, 32'd7, 32'd0, 1'b0);

        $display("[TB] reserved register");
        applyStimulus(1'b0, BASE + 32'hC, 32'd0, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b1, BASE + 32'hC, 32'hAB, 32'd0, 1'b0);
        applyStimulus(1'b0, BASE + 32'h8, 32'd0, 32'd0, 1'b0);
        checkOutput("reserved_no_push", cpu_rdata, 32'd0);

        $display("[TB] overflow");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, BASE, 32'(i), 32'd0, 1'b0);
        applyStimulus(1'b0, BASE + 32'h8, 32'd0, 32'd0, 1'b0);
        checkOutput("count_full", cpu_rdata, 32'd8);
        applyStimulus(1'b0, BASE + 32'h4, 32'd0, 32'd0, 1'b0);
        checkOutput("status_ovf", cpu_rdata, 32'd7);
        applyStimulus(1'b1, BASE + 32'h4, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, BASE + 32'h4, 32'd0, 32'd0, 1'b0);
        checkOutput("status_cleared", cpu_rdata, 32'd3);
        idleCycles(9 * FRAME + 10);

        $display("[TB] back-to-back and reset mid-frame");
        applyStimulus(1'b1, BASE, 32'hA1, 32'd0, 1'b0);
        applyStimulus(1'b1, BASE, 32'hB2, 32'd0, 1'b0);
        idleCycles(2 * FRAME + 5);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, BASE, 32'($urandom_range(0, 255)), 32'd0, 1'b0);
        idleCycles(12);
        applyStimulus(1'b0, 32'h80, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, BASE + 32'h8, 32'd0, 32'd0, 1'b0);
        checkOutput("reset_tx_high", 32'(uart_tx), 32'd1);
        checkOutput("reset_count", cpu_rdata, 32'd0);
        idleCycles(2 * FRAME);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) addr = BASE + 32'($urandom_range(0, 3) * 4);
            else addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            applyStimulus(we, addr, $urandom, $urandom, ($urandom_range(0, 599) == 0));
        end
        idleCycles(DEPTH * FRAME + 10);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
